matrix_scoreboard: RTL

- Sits directly downstream of the instruction buffer, one instance per issue slot.
- Consumes decoded instructions, including matrix micro-ops whose rd advances by the micro-op count.
- Holds each instruction until its source and destination registers have no pending writeback.
- Then forwards it to operand collection/dispatch through a one-entry output register.

---
 rtl/matrix_scoreboard.sv | 123 ++++++++++++
 1 files changed

// File: rtl/matrix_scoreboard.sv
// Per-issue-slot register scoreboard: holds an instruction until its sources and rd are
// free, then issues it through a one-entry output register. SCOREBOARD_PERF_EN adds counters.

module matrix_scoreboard_warp #(
    parameter int NR_BITS  = 6,
    parameter int NUM_REGS = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                set_en,
    input  logic [NR_BITS-1:0]  set_rd,
    input  logic                clr_en,
    input  logic [NR_BITS-1:0]  clr_rd,
    output logic [NUM_REGS-1:0] busy
);
    logic [NUM_REGS-1:0] set_vec, clr_vec;

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (set_en) set_vec[set_rd] = 1'b1;
        if (clr_en) clr_vec[clr_rd] = 1'b1;
        set_vec[0] = 1'b0;
    end

    // Set applied after clear: a new producer owns the register over a stale clear.
    always_ff @(posedge clk) begin
        if (reset) busy <= '0;
        else       busy <= (busy & ~clr_vec) | set_vec;
    end
endmodule

module matrix_scoreboard #(
    parameter int NUM_WARPS = 4,
    parameter int WIS_W     = 2,
    parameter int NR_BITS   = 6,
    parameter int NUM_REGS  = 64,
    parameter int DATAW     = 128
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIS_W-1:0]   in_wis,
    input  logic               in_wb,
    input  logic [NR_BITS-1:0] in_rd,
    input  logic [NR_BITS-1:0] in_rs1,
    input  logic [NR_BITS-1:0] in_rs2,
    input  logic [NR_BITS-1:0] in_rs3,
    input  logic [DATAW-1:0]   in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIS_W-1:0]   out_wis,
    output logic               out_wb,
    output logic [NR_BITS-1:0] out_rd,
    output logic [DATAW-1:0]   out_data,
    input  logic               wb_valid,
    input  logic [WIS_W-1:0]   wb_wis,
    input  logic [NR_BITS-1:0] wb_rd,
    input  logic               wb_eop
`ifdef SCOREBOARD_PERF_EN
    ,
    output logic [43:0]        perf_stalls,
    output logic [43:0]        perf_issued
`endif
);
    logic [NUM_WARPS-1:0][NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0]                wbusy;
    logic                               hazard;
    logic                               accept;

    for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
        matrix_scoreboard_warp #(
            .NR_BITS  (NR_BITS),
            .NUM_REGS (NUM_REGS)
        ) u_warp (
            .clk    (clk),
            .reset  (reset),
            .set_en (accept && in_wb && (in_wis == WIS_W'(w))),
            .set_rd (in_rd),
            .clr_en (wb_valid && wb_eop && (wb_wis == WIS_W'(w))),
            .clr_rd (wb_rd),
            .busy   (busy[w])
        );
    end

    // Hazard looks only at registered busy state; a same-cycle clear is not bypassed.
    assign wbusy    = busy[in_wis];
    assign hazard   = wbusy[in_rs1] | wbusy[in_rs2] | wbusy[in_rs3] | (in_wb & wbusy[in_rd]);
    assign in_ready = !hazard && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_wis   <= '0;
            out_wb    <= 1'b0;
            out_rd    <= '0;
            out_data  <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_wis   <= in_wis;
            out_wb    <= in_wb;
            out_rd    <= in_rd;
            out_data  <= in_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef SCOREBOARD_PERF_EN
    // Output-register backpressure alone is not a scoreboard stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stalls <= '0;
            perf_issued <= '0;
        end else begin
            if (in_valid && hazard) perf_stalls <= perf_stalls + 44'd1;
            if (accept)             perf_issued <= perf_issued + 44'd1;
        end
    end
`endif
endmodule
